// File: rtl/bcd_to_signed.sv
// Serial BCD (MSB digit first) plus sign flag to two's-complement binary, saturating at 2^MAG_W-1.
// Result registered on the last digit handshake (y_valid one cycle later); y/sat/bad_digit hold until y_ready.
module bcd_to_signed #(
  parameter int NUM_DIGITS = 3,
  parameter int MAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_in,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic             digit_ready,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [MAG_W:0]   y,
  output logic             sat,
  output logic             bad_digit
);

  localparam int ACC_W = MAG_W + 4;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [ACC_W-1:0] MAX_MAG  = {4'b0000, {MAG_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign;
  logic             r_sat;
  logic             r_bad;
  logic [MAG_W:0]   r_y;

  logic             w_start_fire;
  logic             w_digit_fire;
  logic             w_last_digit;
  logic             w_y_fire;
  logic             w_digit_bad;
  logic [3:0]       w_digit_eff;
  logic [ACC_W-1:0] w_prod;
  logic             w_over;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [MAG_W:0]   w_mag_ext;
  logic [MAG_W:0]   w_y_nxt;

  assign w_start_fire = (r_state == S_IDLE) && start;
  assign w_digit_fire = digit_valid && digit_ready;
  assign w_last_digit = w_digit_fire && (r_cnt == LAST_IDX);
  assign w_y_fire     = y_valid && y_ready;

  // Out-of-range BCD codes are flagged and decoded as 9.
  assign w_digit_bad = (digit > 4'd9);
  assign w_digit_eff = w_digit_bad ? 4'd9 : digit;

  // acc is clamped to MAX_MAG, so acc*10+9 always fits in ACC_W bits.
  assign w_prod    = (r_acc << 3) + (r_acc << 1) + {{(ACC_W-4){1'b0}}, w_digit_eff};
  assign w_over    = (w_prod > MAX_MAG);
  assign w_acc_nxt = w_over ? MAX_MAG : w_prod;

  // Negating a zero magnitude yields zero, so no negative zero appears.
  assign w_mag_ext = {1'b0, w_acc_nxt[MAG_W-1:0]};
  assign w_y_nxt   = r_sign ? -w_mag_ext : w_mag_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last_digit) w_state_nxt = S_DONE;
      S_DONE:  if (y_ready)      w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    digit_ready = 1'b0;
    y_valid     = 1'b0;
    case (r_state)
      S_ACCUM: digit_ready = 1'b1;
      S_DONE:  y_valid     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_sat  <= 1'b0;
      r_bad  <= 1'b0;
      r_y    <= '0;
    end else if (w_start_fire) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sign <= sign_in;
      r_sat  <= 1'b0;
      r_bad  <= 1'b0;
    end else if (w_digit_fire) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      r_sat <= r_sat | w_over;
      r_bad <= r_bad | w_digit_bad;
      if (w_last_digit) begin
        r_y <= w_y_nxt;
      end
    end
  end

  assign y         = r_y;
  assign sat       = r_sat;
  assign bad_digit = r_bad;

  // w_y_fire only documents the consume condition used by the FSM.
  logic w_unused;
  assign w_unused = w_y_fire;

endmodule
